// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: the operation-select encoding.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        SR_HOLD  = 3'd0,
        SR_SHL   = 3'd1,
        SR_SHR   = 3'd2,
        SR_ROTL  = 3'd3,
        SR_ROTR  = 3'd4,
        SR_LOAD  = 3'd5,
        SR_CLEAR = 3'd6,
        SR_RSVD  = 3'd7
    } shift_mode_e;

endpackage

// File: rtl/univ_shift_reg_frame_ctr.sv
// Fill-level and frame counters for univ_shift_reg: fill saturates at DEPTH,
// the frame counter wraps every DEPTH shifts and emits a one-cycle frame pulse.
module shift_frame_ctr #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          shift,
    input  logic          load,
    input  logic          clear,
    output logic [CW-1:0] fill,
    output logic          frame
);

    localparam int FW = $clog2(DEPTH);

    logic [FW-1:0] fcnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill  <= '0;
            fcnt  <= '0;
            frame <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (en) begin
                if (load || clear) begin
                    fill <= load ? CW'(DEPTH) : '0;
                    fcnt <= '0;
                end else if (shift) begin
                    if (fill != CW'(DEPTH))
                        fill <= fill + CW'(1);
                    if (fcnt == FW'(DEPTH - 1)) begin
                        fcnt  <= '0;
                        frame <= 1'b1;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Multi-lane universal shift register (shift, rotate, load, clear) with fill
// tracking and frame pulse. Optional parity output: UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       sin,
    input  logic [DEPTH*WIDTH-1:0] pin,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic [WIDTH-1:0]       sout_hi,
    output logic [WIDTH-1:0]       sout_lo,
    output logic [CW-1:0]          fill,
    output logic                   full,
    output logic                   frame
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    output logic                   parity
`endif
);

    localparam int N = DEPTH * WIDTH;

    logic [N-1:0] sr;
    logic [N-1:0] sr_nxt;
    logic         do_shift;
    logic         do_load;
    logic         do_clear;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sr_nxt   = sr;
        do_shift = 1'b0;
        do_load  = 1'b0;
        do_clear = 1'b0;
        if (en) begin
            case (shift_mode_e'(mode))
                SR_SHL: begin
                    sr_nxt   = {sr[N-WIDTH-1:0], sin};
                    do_shift = 1'b1;
                end
                SR_SHR: begin
                    sr_nxt   = {sin, sr[N-1:WIDTH]};
                    do_shift = 1'b1;
                end
                SR_ROTL:  sr_nxt = {sr[N-WIDTH-1:0], sr[N-1 -: WIDTH]};
                SR_ROTR:  sr_nxt = {sr[WIDTH-1:0], sr[N-1:WIDTH]};
                SR_LOAD: begin
                    sr_nxt  = pin;
                    do_load = 1'b1;
                end
                SR_CLEAR: begin
                    sr_nxt   = '0;
                    do_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sr <= '0;
        else
            sr <= sr_nxt;
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    // Registered from the next-state value so it lines up with pout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            parity <= 1'b0;
        else
            parity <= ^sr_nxt;
    end
`endif

    shift_frame_ctr #(.DEPTH(DEPTH)) u_ctr (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .shift (do_shift),
        .load  (do_load),
        .clear (do_clear),
        .fill  (fill),
        .frame (frame)
    );

    assign pout    = sr;
    assign sout_hi = sr[N-1 -: WIDTH];
    assign sout_lo = sr[WIDTH-1:0];
    assign full    = (fill == CW'(DEPTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=2, DEPTH=4): directed scenarios
// plus randomized traffic compared every cycle against a stage-array model.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           en = 1'b1;
    logic [2:0]     mode = SR_SHL;
    logic [W-1:0]   sin = 2'b11;
    logic [D*W-1:0] pin = '0;
    logic [D*W-1:0] pout;
    logic [W-1:0]   sout_hi;
    logic [W-1:0]   sout_lo;
    logic [CW-1:0]  fill;
    logic           full;
    logic           frame;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic           parity;
`endif

    int checks = 0;
    int failures = 0;

    univ_shift_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .mode    (mode),
        .sin     (sin),
        .pin     (pin),
        .pout    (pout),
        .sout_hi (sout_hi),
        .sout_lo (sout_lo),
        .fill    (fill),
        .full    (full),
        .frame   (frame)
`ifdef UNIV_SHIFT_REG_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stage array plus shift count since last reset/clear/load.
    logic [W-1:0] m_st [D];
    int           m_fill;
    int           m_shifts;
    bit           m_frame;

    function automatic void m_reset();
        for (int k = 0; k < D; k++) m_st[k] = '0;
        m_fill   = 0;
        m_shifts = 0;
        m_frame  = 0;
    endfunction

    function automatic logic [D*W-1:0] m_pout();
        logic [D*W-1:0] p;
        for (int k = 0; k < D; k++) p[k*W +: W] = m_st[k];
        return p;
    endfunction

    function automatic void m_count();
        m_fill   = (m_fill + 1 > D) ? D : m_fill + 1;
        m_shifts = m_shifts + 1;
        m_frame  = (m_shifts % D) == 0;
    endfunction

    function automatic void m_step();
        logic [W-1:0] old [D];
        old = m_st;
        m_frame = 0;
        if (!en) return;
        case (mode)
            3'd1: begin for (int k = 1; k < D; k++) m_st[k] = old[k-1]; m_st[0] = sin; m_count(); end
            3'd2: begin for (int k = 0; k < D-1; k++) m_st[k] = old[k+1]; m_st[D-1] = sin; m_count(); end
            3'd3: for (int k = 0; k < D; k++) m_st[k] = old[(k + D - 1) % D];
            3'd4: for (int k = 0; k < D; k++) m_st[k] = old[(k + 1) % D];
            3'd5: begin
                for (int k = 0; k < D; k++) m_st[k] = pin[k*W +: W];
                m_fill = D; m_shifts = 0;
            end
            3'd6: begin
                for (int k = 0; k < D; k++) m_st[k] = '0;
                m_fill = 0; m_shifts = 0;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m_reset();
        else       m_step();
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("pout",    pout,    m_pout());
            check("sout_hi", sout_hi, m_st[D-1]);
            check("sout_lo", sout_lo, m_st[0]);
            check("fill",    fill,    m_fill);
            check("full",    full,    m_fill == D);
            check("frame",   frame,   m_frame);
`ifdef UNIV_SHIFT_REG_PARITY_EN
            check("parity",  parity,  ^m_pout());
`endif
        end
    end

    task automatic cyc(input logic e, input logic [2:0] m, input logic [W-1:0] s);
        en = e; mode = m; sin = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [D*W-1:0] saved;
        logic [W-1:0]   seq [4];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        m_reset();

        // Reset held with shifting inputs present
        repeat (2) @(posedge clk);
        #1;
        check("rst_pout", pout, 8'h00);
        check("rst_fill", fill, 0);
        check("rst_frame", frame, 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        check("first_shift_pout", pout, 8'h03);
        check("first_shift_fill", fill, 1);

        // SHL streaming, frame after 4th and 8th shift, fill saturates
        cyc(1'b1, SR_CLEAR, 2'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, SR_SHL, seq[i]);
            check("stream_frame", frame, i == 3);
        end
        check("stream_pout", pout, 8'h6C);
        check("stream_fill", fill, 4);
        check("stream_full", full, 1);
        for (int i = 4; i < 8; i++) begin
            cyc(1'b1, SR_SHL, 2'($urandom));
            check("sat_fill", fill, 4);
            check("sat_frame", frame, i == 7);
        end

        // Load and rotates
        pin = 8'hE4;
        cyc(1'b1, SR_LOAD, 2'd0);
        check("load_pout", pout, 8'hE4);
        check("load_fill", fill, 4);
        cyc(1'b1, SR_ROTR, 2'd3);
        check("rotr_pout", pout, 8'h39);
        check("rotr_frame", frame, 0);
        cyc(1'b1, SR_ROTL, 2'd3);
        check("rotl_pout", pout, 8'hE4);
        check("rotl_fill", fill, 4);
        check("rotl_frame", frame, 0);

        // Enable gating mid-frame
        cyc(1'b1, SR_CLEAR, 2'd0);
        cyc(1'b1, SR_SHL, 2'd1);
        cyc(1'b1, SR_SHL, 2'd2);
        saved = pout;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, SR_SHL, 2'd3);
            check("gate_pout", pout, saved);
            check("gate_fill", fill, 2);
            check("gate_frame", frame, 0);
        end
        cyc(1'b1, SR_SHL, 2'd3);
        check("gate_frame3", frame, 0);
        cyc(1'b1, SR_SHL, 2'd0);
        check("gate_frame4", frame, 1);

        // Reserved mode and clear
        saved = pout;
        cyc(1'b1, SR_RSVD, 2'd3);
        check("rsvd_pout", pout, saved);
        check("rsvd_fill", fill, 4);
        cyc(1'b1, SR_SHL, 2'd1);
        cyc(1'b1, SR_SHL, 2'd2);
        cyc(1'b1, SR_CLEAR, 2'd3);
        check("clear_pout", pout, 8'h00);
        check("clear_fill", fill, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, SR_SHR, 2'($urandom));
            check("post_clear_frame", frame, i == 3);
        end

        // Asynchronous reset between edges after 3 shifts
        cyc(1'b1, SR_CLEAR, 2'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, SR_SHL, 2'd3);
        #2 rstn = 1'b0;
        #1;
        check("arst_pout", pout, 8'h00);
        check("arst_fill", fill, 0);
        check("arst_full", full, 0);
        check("arst_frame", frame, 0);
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, SR_SHL, 2'd2);
            check("post_arst_frame", frame, i == 3);
        end

        // Randomized traffic, weighted toward shifts
        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            logic [2:0]  m;
            r = $urandom_range(0, 15);
            m = (r < 5) ? 3'(SR_SHL) : (r < 10) ? 3'(SR_SHR) : 3'($urandom_range(0, 7));
            pin = 8'($urandom);
            cyc($urandom_range(0, 7) != 0, m, 2'($urandom));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
